hpdmc_fml_initiator: RTL and testbench

- FML bus master that drives the HPDMC FML slave port from a simple single-request client interface.
- Client requests one 4-beat, 64-bit burst (32 bytes). Block issues the FML strobe/address phase, waits for fml_ack, then streams write data out or collects read data in.
- Sits between a client (DMA engine, bus bridge, test master) and the HPDMC bus interface. It is the initiator end of the same FML link.

---
 rtl/hpdmc_fml_initiator.sv | 193 +++++++++++++++++++
 tb/tb_hpdmc_fml_initiator.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_fml_initiator.sv
// -----------------------------------------------------------------------------
// hpdmc_fml_initiator
//
// FML bus master. It turns one client request into a single 4-beat, 64-bit
// FML burst (32 bytes) towards the HPDMC FML slave port.
//
// Flow: IDLE -> REQ (strobe/address phase, wait for fml_ack)
//            -> WBURST (write beats 1..3) or RBURST (read beats 0..3)
//            -> DONE (one-cycle completion pulse, accepts the next request)
//
// Ports
//   sys_clk, sdram_rst_n      clock, asynchronous active-low reset
//   req_stb/req_we/req_adr    client request (sampled when req_busy=0)
//   req_wdata/req_wsel        write burst data / byte enables, beat n in slice n
//   req_busy/req_done         request in progress / completion pulse
//   req_rdata                 read burst result, held until the next read ends
//   fml_adr/fml_stb/fml_we    FML address phase (address is burst aligned)
//   fml_ack                   FML acknowledge from the slave
//   fml_sel/fml_do            FML write byte enables / write data
//   fml_di                    FML read data
//
// All outputs are registered: each one is computed from the next-state value
// so that, for example, write beat 0 is already on fml_do for the whole REQ
// state and therefore in the ack cycle.
// -----------------------------------------------------------------------------
module hpdmc_fml_initiator #(
    parameter int sdram_depth = 26
) (
    input  logic                   sys_clk,
    input  logic                   sdram_rst_n,
    input  logic                   req_stb,
    input  logic                   req_we,
    input  logic [sdram_depth-1:0] req_adr,
    input  logic [255:0]           req_wdata,
    input  logic [31:0]            req_wsel,
    output logic                   req_busy,
    output logic                   req_done,
    output logic [255:0]           req_rdata,
    output logic [sdram_depth-1:0] fml_adr,
    output logic                   fml_stb,
    output logic                   fml_we,
    input  logic                   fml_ack,
    output logic [7:0]             fml_sel,
    output logic [63:0]            fml_do,
    input  logic [63:0]            fml_di
);

    // Clears the five low byte-address bits so the burst is 32-byte aligned.
    localparam logic [sdram_depth-1:0] ADR_MASK = {{(sdram_depth-5){1'b1}}, 5'b00000};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WBURST = 3'd2,
        ST_RBURST = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [1:0]               beat_r;
    logic [1:0]               beat_s;
    logic                     we_r;
    logic                     we_s;
    logic [255:0]             wdata_r;
    logic [255:0]             wdata_s;
    logic [31:0]              wsel_r;
    logic [31:0]              wsel_s;
    logic                     capture_s;
    logic                     rcap_s;
    logic [sdram_depth-1:0]   adr_s;
    logic [63:0]              do_s;
    logic [7:0]               sel_s;
    logic [255:0]             rdata_s;

    // Next-state and beat-counter logic.
    always_comb begin
        state_s   = state_r;
        beat_s    = beat_r;
        capture_s = 1'b0;
        rcap_s    = 1'b0;
        case (state_r)
            // DONE behaves like IDLE for request capture, so requests can be
            // issued back to back in the completion cycle.
            ST_IDLE, ST_DONE: begin
                if (req_stb) begin
                    capture_s = 1'b1;
                    state_s   = ST_REQ;
                    beat_s    = 2'd0;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (fml_ack) begin
                    if (we_r) begin
                        // The ack cycle itself carried write beat 0.
                        state_s = ST_WBURST;
                        beat_s  = 2'd1;
                    end else begin
                        state_s = ST_RBURST;
                        beat_s  = 2'd0;
                    end
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WBURST, ST_RBURST: begin
                rcap_s = (state_r == ST_RBURST);
                if (beat_r == 2'd3) begin
                    state_s = ST_DONE;
                    beat_s  = 2'd0;
                end else begin
                    beat_s  = beat_r + 2'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                beat_s  = 2'd0;
            end
        endcase
    end

    // Next values of the captured request and of every registered output.
    always_comb begin
        we_s    = we_r;
        wdata_s = wdata_r;
        wsel_s  = wsel_r;
        adr_s   = fml_adr;
        do_s    = 64'd0;
        sel_s   = 8'd0;
        rdata_s = req_rdata;
        if (capture_s) begin
            we_s    = req_we;
            wdata_s = req_wdata;
            wsel_s  = req_wsel;
            adr_s   = req_adr & ADR_MASK;
        end else begin
            we_s    = we_r;
        end
        if (((state_s == ST_REQ) || (state_s == ST_WBURST)) && we_s) begin
            do_s  = wdata_s[{beat_s, 6'd0} +: 64];
            sel_s = wsel_s[{beat_s, 3'd0} +: 8];
        end else begin
            do_s  = 64'd0;
            sel_s = 8'd0;
        end
        if (rcap_s) begin
            case (beat_r)
                2'd0:    rdata_s[63:0]    = fml_di;
                2'd1:    rdata_s[127:64]  = fml_di;
                2'd2:    rdata_s[191:128] = fml_di;
                default: rdata_s[255:192] = fml_di;
            endcase
        end else begin
            rdata_s = req_rdata;
        end
    end

    // State, captured request and output registers.
    always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_r   <= ST_IDLE;
            beat_r    <= 2'd0;
            we_r      <= 1'b0;
            wdata_r   <= 256'd0;
            wsel_r    <= 32'd0;
            fml_adr   <= '0;
            fml_stb   <= 1'b0;
            fml_we    <= 1'b0;
            fml_sel   <= 8'd0;
            fml_do    <= 64'd0;
            req_busy  <= 1'b0;
            req_done  <= 1'b0;
            req_rdata <= 256'd0;
        end else begin
            state_r   <= state_s;
            beat_r    <= beat_s;
            we_r      <= we_s;
            wdata_r   <= wdata_s;
            wsel_r    <= wsel_s;
            fml_adr   <= adr_s;
            fml_stb   <= (state_s == ST_REQ);
            fml_we    <= (state_s == ST_REQ) && we_s;
            fml_sel   <= sel_s;
            fml_do    <= do_s;
            req_busy  <= (state_s == ST_REQ) || (state_s == ST_WBURST) || (state_s == ST_RBURST);
            req_done  <= (state_s == ST_DONE);
            req_rdata <= rdata_s;
        end
    end

endmodule

// File: tb/tb_hpdmc_fml_initiator.sv
// -----------------------------------------------------------------------------
// tb_hpdmc_fml_initiator
//
// Timeline-based reference: when a request is issued at cycle t0 with w wait
// cycles before fml_ack, every output for cycles t0+1 .. completion follows
// from simple arithmetic (strobe for w+1 cycles, write beats at ack+0..3,
// read beats sampled at ack+1..4, done at ack+4 / ack+5). The driver writes
// these per-cycle expectations into arrays; one compare process checks the
// DUT against them at every falling edge. A monitor records observed timing
// for a few literal checks that pin the model itself.
// -----------------------------------------------------------------------------
module tb_hpdmc_fml_initiator;

    localparam int NC = 4000;

    logic         sys_clk;
    logic         sdram_rst_n;
    logic         req_stb;
    logic         req_we;
    logic [25:0]  req_adr;
    logic [255:0] req_wdata;
    logic [31:0]  req_wsel;
    logic         req_busy;
    logic         req_done;
    logic [255:0] req_rdata;
    logic [25:0]  fml_adr;
    logic         fml_stb;
    logic         fml_we;
    logic         fml_ack;
    logic [7:0]   fml_sel;
    logic [63:0]  fml_do;
    logic [63:0]  fml_di;

    hpdmc_fml_initiator #(.sdram_depth(26)) dut (
        .sys_clk     (sys_clk),
        .sdram_rst_n (sdram_rst_n),
        .req_stb     (req_stb),
        .req_we      (req_we),
        .req_adr     (req_adr),
        .req_wdata   (req_wdata),
        .req_wsel    (req_wsel),
        .req_busy    (req_busy),
        .req_done    (req_done),
        .req_rdata   (req_rdata),
        .fml_adr     (fml_adr),
        .fml_stb     (fml_stb),
        .fml_we      (fml_we),
        .fml_ack     (fml_ack),
        .fml_sel     (fml_sel),
        .fml_do      (fml_do),
        .fml_di      (fml_di)
    );

    // Clock generation.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // Per-cycle expectations (index = cycle number).
    logic        exp_stb  [NC];
    logic        exp_busy [NC];
    logic        exp_done [NC];
    logic        chk_aw   [NC];
    logic [25:0] exp_adr  [NC];
    logic        exp_we   [NC];
    logic [7:0]  exp_sel  [NC];
    logic [63:0] exp_do   [NC];
    logic        upd_v    [NC];
    logic [1:0]  upd_k    [NC];
    logic [63:0] upd_d    [NC];
    logic [255:0] mdl_rdata = 256'd0;

    // Monitor observations.
    int          n_txn = 0;
    int          stb_len = 0;
    int          adr_moves = 0;
    int          ack_cyc = 0;
    int          done_cyc = 0;
    logic [25:0] first_adr = 26'd0;
    logic        prev_stb = 1'b0;
    logic [63:0] do_q [$];

    // Cycle counter.
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_cycle(input int c);
        if (c < NC) begin
            exp_stb[c]  = 1'b0;
            exp_busy[c] = 1'b0;
            exp_done[c] = 1'b0;
            chk_aw[c]   = 1'b0;
            exp_adr[c]  = 26'd0;
            exp_we[c]   = 1'b0;
            exp_sel[c]  = 8'd0;
            exp_do[c]   = 64'd0;
            upd_v[c]    = 1'b0;
            upd_k[c]    = 2'd0;
            upd_d[c]    = 64'd0;
        end
    endtask

    // Compare process: DUT outputs against the per-cycle model.
    always @(negedge sys_clk) begin
        if (started && cyc < NC) begin
            if (!sdram_rst_n) mdl_rdata = 256'd0;
            if (upd_v[cyc]) mdl_rdata[upd_k[cyc]*64 +: 64] = upd_d[cyc];
            chk("fml_stb",   {255'd0, fml_stb},  {255'd0, exp_stb[cyc]});
            chk("req_busy",  {255'd0, req_busy}, {255'd0, exp_busy[cyc]});
            chk("req_done",  {255'd0, req_done}, {255'd0, exp_done[cyc]});
            chk("fml_sel",   {248'd0, fml_sel},  {248'd0, exp_sel[cyc]});
            chk("fml_do",    {192'd0, fml_do},   {192'd0, exp_do[cyc]});
            chk("req_rdata", req_rdata, mdl_rdata);
            if (!sdram_rst_n) begin
                chk("fml_adr_rst", {230'd0, fml_adr}, 256'd0);
                chk("fml_we_rst",  {255'd0, fml_we},  256'd0);
            end else if (chk_aw[cyc]) begin
                chk("fml_adr", {230'd0, fml_adr}, {230'd0, exp_adr[cyc]});
                chk("fml_we",  {255'd0, fml_we},  {255'd0, exp_we[cyc]});
            end else begin
                mdl_rdata = mdl_rdata;
            end
        end
    end

    // Monitor: observed transaction timing and write beats.
    always @(negedge sys_clk) begin
        if (started && sdram_rst_n) begin
            if (fml_stb && !prev_stb) begin
                n_txn++;
                stb_len = 0;
                first_adr = fml_adr;
            end
            if (fml_stb) begin
                stb_len++;
                if (fml_adr !== first_adr) adr_moves++;
                if (fml_ack) ack_cyc = cyc;
            end
            if (req_done) done_cyc = cyc;
            if (fml_sel != 8'd0) do_q.push_back(fml_do);
        end
        prev_stb = fml_stb;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic mon_clear();
        n_txn = 0;
        adr_moves = 0;
        do_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            req_stb = 1'b0;
            fml_ack = 1'($urandom_range(0, 1));
            fml_di  = {$urandom, $urandom};
            tick();
        end
    endtask

    // One request: fills the expectation timeline, then drives the bus.
    task automatic do_txn(input logic we, input logic [25:0] adr, input logic [255:0] wd,
                          input logic [31:0] ws, input logic [255:0] rd, input int waits,
                          input bit poke, input bit spur, input bit abort);
        int t0;
        int a;
        int dc;
        t0 = cyc;
        a  = t0 + 1 + waits;
        dc = we ? a + 4 : a + 5;
        for (int c = t0 + 1; c <= a; c++) begin
            exp_stb[c]  = 1'b1;
            exp_busy[c] = 1'b1;
            chk_aw[c]   = 1'b1;
            exp_adr[c]  = adr & 26'h3FFFFE0;
            exp_we[c]   = we;
            if (we) begin
                exp_sel[c] = ws[7:0];
                exp_do[c]  = wd[63:0];
            end
        end
        for (int k = 1; k < 4 && we; k++) begin
            exp_busy[a+k] = 1'b1;
            exp_sel[a+k]  = ws[k*8 +: 8];
            exp_do[a+k]   = wd[k*64 +: 64];
        end
        for (int k = 0; k < 4 && !we; k++) begin
            exp_busy[a+1+k] = 1'b1;
            upd_v[a+2+k]    = 1'b1;
            upd_k[a+2+k]    = 2'(k);
            upd_d[a+2+k]    = rd[k*64 +: 64];
        end
        exp_done[dc] = 1'b1;

        req_stb   = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_wdata = wd;
        req_wsel  = ws;
        fml_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        fml_di    = {$urandom, $urandom};
        for (int c = t0 + 1; c <= dc; c++) begin
            tick();
            if (abort && c == a + 3) begin
                sdram_rst_n = 1'b0;
                for (int j = c; j <= dc + 1; j++) clear_cycle(j);
                req_stb = 1'b0;
                fml_ack = 1'b0;
                tick();
                tick();
                sdram_rst_n = 1'b1;
                return;
            end
            req_stb   = (poke && c < dc) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_we    = 1'($urandom_range(0, 1));
            req_adr   = 26'($urandom);
            req_wdata = rnd256();
            req_wsel  = $urandom;
            if (c == a)                fml_ack = 1'b1;
            else if (c > a && spur)    fml_ack = 1'($urandom_range(0, 1));
            else                       fml_ack = 1'b0;
            if (!we && c > a && c <= a + 4) fml_di = rd[(c-a-1)*64 +: 64];
            else                            fml_di = {$urandom, $urandom};
        end
    endtask

    logic [255:0] wd_dir;
    logic [255:0] rd_dir;

    // Main stimulus sequence.
    initial begin
        sdram_rst_n = 1'b0;
        req_stb     = 1'b1;
        req_we      = 1'b1;
        req_adr     = 26'h3FFFFFF;
        req_wdata   = 256'd0;
        req_wsel    = 32'hFFFFFFFF;
        fml_ack     = 1'b0;
        fml_di      = 64'd0;
        for (int c = 0; c < NC; c++) clear_cycle(c);
        started = 1'b1;

        // Reset held with a toggling ack and an active request.
        repeat (6) begin
            tick();
            fml_ack = ~fml_ack;
        end
        req_stb = 1'b0;
        fml_ack = 1'b0;
        tick();
        sdram_rst_n = 1'b1;
        tick();

        // Directed zero-wait write.
        wd_dir = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        mon_clear();
        do_txn(1'b1, 26'h0123457, wd_dir, 32'hFFFFFFFF, 256'd0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("wr_txn_count", 256'(n_txn), 256'd1);
        chk("wr_stb_len", 256'(stb_len), 256'd1);
        chk("wr_adr", {230'd0, first_adr}, {230'd0, 26'h0123440});
        chk("wr_ack_to_done", 256'(done_cyc - ack_cyc), 256'd4);
        chk("wr_beat_count", 256'(do_q.size()), 256'd4);
        if (do_q.size() == 4) begin
            chk("wr_beat0", {192'd0, do_q[0]}, {192'd0, 64'h1111_1111_1111_1111});
            chk("wr_beat1", {192'd0, do_q[1]}, {192'd0, 64'h2222_2222_2222_2222});
            chk("wr_beat2", {192'd0, do_q[2]}, {192'd0, 64'h3333_3333_3333_3333});
            chk("wr_beat3", {192'd0, do_q[3]}, {192'd0, 64'h4444_4444_4444_4444});
        end

        // Directed read with five wait cycles and spurious acks.
        rd_dir = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        mon_clear();
        idle(1);
        do_txn(1'b0, 26'h2ABCDEF, 256'd0, 32'd0, rd_dir, 5, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("rd_stb_len", 256'(stb_len), 256'd6);
        chk("rd_adr_stable", 256'(adr_moves), 256'd0);
        chk("rd_adr", {230'd0, first_adr}, {230'd0, 26'h2ABCDE0});
        chk("rd_ack_to_done", 256'(done_cyc - ack_cyc), 256'd5);
        chk("rd_data", req_rdata, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

        // Busy rejection, then a new request issued in the done cycle.
        mon_clear();
        do_txn(1'b1, 26'h0000100, rnd256(), $urandom, 256'd0, 1, 1'b1, 1'b1, 1'b0);
        do_txn(1'b0, 26'h0000200, 256'd0, 32'd0, rnd256(), 0, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("busy_txn_count", 256'(n_txn), 256'd2);

        // Reset in the middle of a read, then a normal read.
        do_txn(1'b0, 26'h0000300, 256'd0, 32'd0, rnd256(), 2, 1'b0, 1'b1, 1'b1);
        chk("abort_rdata", req_rdata, 256'd0);
        chk("abort_busy", {255'd0, req_busy}, 256'd0);
        chk("abort_stb", {255'd0, fml_stb}, 256'd0);
        idle(1);
        do_txn(1'b0, 26'h0000400, 256'd0, 32'd0, rd_dir, 1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("post_abort_rd", req_rdata, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

        // Randomized traffic.
        for (int i = 0; i < 60 && cyc < NC - 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), 26'($urandom), rnd256(), $urandom, rnd256(),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
